// File: rtl/ondra_audio_mixer.sv
// N-channel gain-weighted audio mixer: snapshots all channels on sample_ce, accumulates one
// channel per clock, then scales and saturates the sum into an unsigned output sample.
module ondra_audio_mixer #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned IN_W   = 14,
    parameter int unsigned GAIN_W = 4,
    parameter int unsigned SHIFT  = 2,
    parameter int unsigned OUT_W  = 16
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     sample_ce,
    input  logic [NUM_CH*IN_W-1:0]   ch_data,
    input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
    input  logic [NUM_CH-1:0]        ch_en,
    output logic [OUT_W-1:0]         audio_out,
    output logic                     audio_valid,
    output logic                     busy,
    output logic                     overrun,
    output logic                     clip
);

    localparam int unsigned PROD_W = IN_W + GAIN_W;
    localparam int unsigned ACC_W  = PROD_W + $clog2(NUM_CH) + 1;
    localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CMP_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CH - 1);
    localparam logic [CMP_W-1:0] SatMax  = {{(CMP_W - OUT_W){1'b0}}, {OUT_W{1'b1}}};

    typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

    state_e                  state_q, state_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IN_W-1:0]         snap_data_q [NUM_CH];
    logic [GAIN_W-1:0]       snap_gain_q [NUM_CH];
    logic [NUM_CH-1:0]       snap_en_q;
    logic [OUT_W-1:0]        out_q, out_d;
    logic                    clip_q, clip_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic                    load;

    logic [IN_W-1:0]         cur_data;
    logic [GAIN_W-1:0]       cur_gain;
    logic                    cur_en;
    logic [PROD_W-1:0]       prod;
    logic [CMP_W-1:0]        scaled;

    // Explicit compare-select avoids indexing the snapshot with a possibly oversized index.
    always_comb begin
        cur_data = '0;
        cur_gain = '0;
        cur_en   = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_data = snap_data_q[k];
                cur_gain = snap_gain_q[k];
                cur_en   = snap_en_q[k];
            end
        end
        prod   = cur_en ? (PROD_W'(cur_data) * PROD_W'(cur_gain)) : '0;
        scaled = CMP_W'(acc_q) >> SHIFT;
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        out_d     = out_q;
        clip_d    = clip_q;
        valid_d   = 1'b0;
        load      = 1'b0;
        overrun_d = sample_ce && (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
                if (sample_ce) begin
                    load    = 1'b1;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = StAcc;
                end
            end
            StAcc: begin
                acc_d = acc_q + ACC_W'(prod);
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LastIdx) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                if (scaled > SatMax) begin
                    out_d  = '1;
                    clip_d = 1'b1;
                end else begin
                    out_d  = scaled[OUT_W-1:0];
                    clip_d = 1'b0;
                end
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            idx_q     <= '0;
            out_q     <= '0;
            clip_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            snap_en_q <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                snap_data_q[k] <= '0;
                snap_gain_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            out_q     <= out_d;
            clip_q    <= clip_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            if (load) begin
                snap_en_q <= ch_en;
                for (int k = 0; k < NUM_CH; k++) begin
                    snap_data_q[k] <= ch_data[k*IN_W +: IN_W];
                    snap_gain_q[k] <= ch_gain[k*GAIN_W +: GAIN_W];
                end
            end
        end
    end

    assign audio_out   = out_q;
    assign audio_valid = valid_q;
    assign busy        = (state_q != StIdle);
    assign overrun     = overrun_q;
    assign clip        = clip_q;

endmodule

// File: tb/tb_ondra_audio_mixer.sv
// Directed bench for ondra_audio_mixer: default build plus a NUM_CH=1 narrow build.
module tb_ondra_audio_mixer;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b0;

    logic        sample_ce = 1'b0;
    logic [55:0] ch_data   = '0;
    logic [15:0] ch_gain   = '0;
    logic [3:0]  ch_en     = '0;
    logic [15:0] audio_out;
    logic        audio_valid, busy, overrun, clip;

    logic        sample_ce1 = 1'b0;
    logic [7:0]  ch_data1   = '0;
    logic [1:0]  ch_gain1   = '0;
    logic [0:0]  ch_en1     = '0;
    logic [9:0]  audio_out1;
    logic        audio_valid1, busy1, overrun1, clip1;

    int checks = 0;
    int errors = 0;
    int lat, bc, ov, nvalid;
    logic [15:0] captured;

    ondra_audio_mixer dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .sample_ce   (sample_ce),
        .ch_data     (ch_data),
        .ch_gain     (ch_gain),
        .ch_en       (ch_en),
        .audio_out   (audio_out),
        .audio_valid (audio_valid),
        .busy        (busy),
        .overrun     (overrun),
        .clip        (clip)
    );

    ondra_audio_mixer #(
        .NUM_CH (1),
        .IN_W   (8),
        .GAIN_W (2),
        .SHIFT  (0),
        .OUT_W  (10)
    ) dut1 (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .sample_ce   (sample_ce1),
        .ch_data     (ch_data1),
        .ch_gain     (ch_gain1),
        .ch_en       (ch_en1),
        .audio_out   (audio_out1),
        .audio_valid (audio_valid1),
        .busy        (busy1),
        .overrun     (overrun1),
        .clip        (clip1)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic [13:0] d, input logic [3:0] g, input logic e);
        ch_data[k*14 +: 14] = d;
        ch_gain[k*4 +: 4]   = g;
        ch_en[k]            = e;
    endtask

    task automatic start_mix();
        sample_ce = 1'b1;
        step();
        sample_ce = 1'b0;
    endtask

    // Called right after the edge that sampled sample_ce; returns at the audio_valid cycle.
    task automatic wait_valid(output int l, output int b, output int o);
        l = 0;
        b = busy ? 1 : 0;
        o = 0;
        while (!audio_valid && l < 30) begin
            step();
            l++;
            if (busy) b++;
            if (overrun) o++;
        end
    endtask

    initial begin
        // Reset state
        #1 reset = 1'b1;
        #1;
        check("rst_out", audio_out, 16'h0000);
        check("rst_valid", audio_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_clip", clip, 1'b0);
        check("rst_out1", audio_out1, 10'h000);
        step();
        step();
        reset = 1'b0;
        step();

        // Narrow build: 0xFF * 3 = 765, two edges
        ch_data1   = 8'hFF;
        ch_gain1   = 2'd3;
        ch_en1     = 1'b1;
        sample_ce1 = 1'b1;
        step();
        sample_ce1 = 1'b0;
        lat = 0;
        while (!audio_valid1 && lat < 20) begin
            step();
            lat++;
        end
        check("p1_lat", lat, 2);
        check("p1_out", audio_out1, 10'h2FD);
        check("p1_clip", clip1, 1'b0);

        // Single channel: 0x3FFF*15 = 245745 >> 2 = 0xEFFC; disabled channels carry junk
        set_ch(0, 14'h3FFF, 4'd15, 1'b1);
        set_ch(1, 14'h1234, 4'd7, 1'b0);
        set_ch(2, 14'h2AAA, 4'd15, 1'b0);
        set_ch(3, 14'h0000, 4'd0, 1'b0);
        start_mix();
        check("t1_busy_start", busy, 1'b1);
        wait_valid(lat, bc, ov);
        check("t1_lat", lat, 5);
        check("t1_busy_cycles", bc, 5);
        check("t1_out", audio_out, 16'hEFFC);
        check("t1_clip", clip, 1'b0);
        check("t1_busy_end", busy, 1'b0);
        step();
        check("t1_valid_pulse", audio_valid, 1'b0);
        check("t1_hold", audio_out, 16'hEFFC);

        // Saturation
        for (int k = 0; k < 4; k++) set_ch(k, 14'h3FFF, 4'd15, 1'b1);
        start_mix();
        wait_valid(lat, bc, ov);
        check("t2_out", audio_out, 16'hFFFF);
        check("t2_clip", clip, 1'b1);
        step();
        check("t2_clip_hold", clip, 1'b1);
        for (int k = 0; k < 4; k++) set_ch(k, 14'h0100, 4'd1, 1'b1);
        start_mix();
        wait_valid(lat, bc, ov);
        check("t2b_out", audio_out, 16'h0100);
        check("t2b_clip", clip, 1'b0);

        // Enable and snapshot: 0x300*3 = 2304 >> 2 = 0x240; ch1 disabled
        set_ch(0, 14'h0300, 4'd3, 1'b1);
        set_ch(1, 14'h1000, 4'd8, 1'b0);
        set_ch(2, 14'h0000, 4'd0, 1'b0);
        set_ch(3, 14'h0000, 4'd0, 1'b0);
        start_mix();
        set_ch(0, 14'h3FFF, 4'd15, 1'b1);
        set_ch(1, 14'h1000, 4'd8, 1'b1);
        wait_valid(lat, bc, ov);
        check("t3_out", audio_out, 16'h0240);

        // Overrun: 0x400*3 = 3072 >> 2 = 0x300
        set_ch(0, 14'h0400, 4'd3, 1'b1);
        set_ch(1, 14'h0000, 4'd0, 1'b0);
        start_mix();
        step();
        sample_ce = 1'b1;
        set_ch(0, 14'h0001, 4'd1, 1'b1);
        step();
        sample_ce = 1'b0;
        check("t4_overrun", overrun, 1'b1);
        step();
        check("t4_overrun_pulse", overrun, 1'b0);
        nvalid   = 0;
        captured = '0;
        for (int i = 0; i < 10; i++) begin
            if (audio_valid) begin
                nvalid++;
                captured = audio_out;
            end
            step();
        end
        check("t4_valid_count", nvalid, 1);
        check("t4_out", captured, 16'h0300);

        // Back-to-back: strobe in the audio_valid cycle; 0x100*1 >> 2 = 0x40
        set_ch(0, 14'h0400, 4'd3, 1'b1);
        start_mix();
        wait_valid(lat, bc, ov);
        check("t5a_out", audio_out, 16'h0300);
        set_ch(0, 14'h0100, 4'd1, 1'b1);
        start_mix();
        check("t5_no_overrun_edge", overrun, 1'b0);
        check("t5_busy", busy, 1'b1);
        wait_valid(lat, bc, ov);
        check("t5_lat", lat, 5);
        check("t5_overruns", ov, 0);
        check("t5_out", audio_out, 16'h0040);

        // Reset mid-mix at index 2, after a clipping result so clip is stale-high
        for (int k = 0; k < 4; k++) set_ch(k, 14'h3FFF, 4'd15, 1'b1);
        start_mix();
        wait_valid(lat, bc, ov);
        check("t6_pre_clip", clip, 1'b1);
        start_mix();
        step();
        step();
        reset = 1'b1;
        #1;
        check("t6_out", audio_out, 16'h0000);
        check("t6_busy", busy, 1'b0);
        check("t6_valid", audio_valid, 1'b0);
        check("t6_clip", clip, 1'b0);
        check("t6_overrun", overrun, 1'b0);
        step();
        reset = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (audio_valid || busy) nvalid++;
        end
        check("t6_no_resume", nvalid, 0);
        set_ch(0, 14'h0300, 4'd3, 1'b1);
        for (int k = 1; k < 4; k++) set_ch(k, 14'h0000, 4'd0, 1'b0);
        start_mix();
        wait_valid(lat, bc, ov);
        check("t6_lat", lat, 5);
        check("t6_out_after", audio_out, 16'h0240);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ondra_audio_mixer.md
Name: ondra_audio_mixer

Overview:
- Parametrised N-channel audio mixer. Replaces the fixed OR-combining of beeper, tape pass-through and MELODIK PSG outputs at the top level.
- On each sample strobe it snapshots all channels and accumulates them sequentially, one channel per clock. Each channel is gain-weighted and individually enabled.
- The sum is scaled and saturated, then presented as an unsigned sample to AUDIO_L/AUDIO_R.
- Runs in the clk_sys domain.

Parameters:
- NUM_CH, 4, number of input channels (1..16).
- IN_W, 14, width of each unsigned channel sample.
- GAIN_W, 4, width of each per-channel gain. 0 = silent; 2^GAIN_W-1 = maximum.
- SHIFT, 2, right shift applied to the accumulated sum before saturation.
- OUT_W, 16, output sample width.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sample_ce  in  1  sample strobe, one clk_sys cycle wide.
- ch_data  in  NUM_CH*IN_W  unsigned channel samples; channel k occupies bits [k*IN_W +: IN_W].
- ch_gain  in  NUM_CH*GAIN_W  per-channel gain, same packing as ch_data.
- ch_en  in  NUM_CH  per-channel enable; 0 contributes nothing.
- audio_out  out  OUT_W  mixed unsigned sample, held between updates.
- audio_valid  out  1  one-cycle pulse when audio_out updates.
- busy  out  1  high while a mix is in progress.
- overrun  out  1  one-cycle pulse when a sample_ce is dropped.
- clip  out  1  saturation flag of the last sample, updated together with audio_out.

Behaviour:
- Reset (asynchronous, immediate, from any state): audio_out=0, audio_valid=0, busy=0, overrun=0, clip=0, state=IDLE, accumulator=0, index=0.
- Widths:
  - Product per channel: IN_W+GAIN_W bits, unsigned.
  - Accumulator: IN_W+GAIN_W+clog2(NUM_CH)+1 bits, so it never wraps.
- State IDLE:
  - On sample_ce=1, register snapshot copies of ch_data, ch_gain and ch_en.
  - Clear the accumulator and set index=0.
  - Go to ACC and set busy=1.
  - Later input changes do not affect the current mix.
- State ACC, one channel per clock:
  - accumulator += snap_en[index] ? snap_data[index]*snap_gain[index] : 0.
  - index increments after each add.
  - After channel NUM_CH-1 is added, go to OUT.
- State OUT (one cycle):
  - s = accumulator >> SHIFT.
  - If s > 2^OUT_W-1: audio_out = all ones, clip=1. Otherwise audio_out = s[OUT_W-1:0], clip=0.
  - audio_valid=1 for this cycle only; busy=0; return to IDLE.
- Latency: audio_valid is high in the cycle following the (NUM_CH+1)-th rising edge after the edge that sampled sample_ce. Default NUM_CH=4 gives 5 edges.
- busy is high for exactly NUM_CH+1 cycles per mix. busy falls on the same edge on which audio_valid rises.
- sample_ce while busy=1:
  - The strobe is ignored and the current mix continues unaffected.
  - overrun pulses high for one cycle, on the edge after the dropped strobe.
- sample_ce in the cycle where audio_valid=1: the block is IDLE, so the strobe is accepted. This gives back-to-back mixes with no overrun.
- Between updates, audio_out and clip hold their last values.
- A channel with all of ch_en=0, gain=0 and data=0 must produce an identical result.
- Reset asserted mid-mix: the partial result is discarded and audio_out returns to 0. No audio_valid is produced for that sample.

Test Plan:
- Single channel, default parameters: ch0 data=0x3FFF, gain=15, en=1; other channels en=0. Pulse sample_ce -> audio_valid after 5 edges, audio_out=0xEFFC (245745>>2), clip=0, busy high exactly 5 cycles.
- Saturation: all four channels data=0x3FFF, gain=15, en=1 -> audio_out=0xFFFF, clip=1. Then set every channel data=0x0100, gain=1 and strobe -> audio_out=0x0100 (1024>>2 = 256), clip=0.
- Enable and snapshot:
  - ch1 data=0x1000, gain=8, en=0 -> contributes 0.
  - Change ch0 data in the cycle after sample_ce -> the result uses the pre-change value.
- Overrun:
  - Pulse sample_ce, then pulse it again 2 cycles later -> overrun pulse on the edge after the second strobe, exactly one audio_valid, result unchanged.
  - Strobe in the audio_valid cycle -> accepted, second audio_valid 5 edges later, no overrun.
- Reset mid-mix: assert reset while busy=1 at index 2 -> all outputs 0 immediately. After release, a new strobe mixes correctly with no stale accumulation.
- Parametrisation: build with NUM_CH=1, IN_W=8, GAIN_W=2, SHIFT=0, OUT_W=10. Data 0xFF, gain 3 -> audio_out=765 (0x2FD) after 2 edges, clip=0.
